// File: rtl/multichan_diff_filter_if.sv
// Sample-in / result-out handshake bundle for multichan_diff_filter.
// The filter is the slave; the front end and downstream logic together form the master.
interface multichan_diff_filter_if #(
    parameter int DW  = 16,
    parameter int CHW = 2
);
    logic           IN_VALID;
    logic           IN_READY;
    logic [CHW-1:0] IN_CH;
    logic [DW-1:0]  IN_DATA;
    logic [1:0]     MODE;
    logic           OUT_VALID;
    logic           OUT_READY;
    logic [CHW-1:0] OUT_CH;
    logic [DW-1:0]  OUT_DATA;
    logic           OUT_SAT;

    modport master (
        output IN_VALID, IN_CH, IN_DATA, MODE, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_CH, OUT_DATA, OUT_SAT
    );

    modport slave (
        input  IN_VALID, IN_CH, IN_DATA, MODE, OUT_READY,
        output IN_READY, OUT_VALID, OUT_CH, OUT_DATA, OUT_SAT
    );
endinterface

// File: rtl/multichan_diff_filter.sv
// Multi-channel bypass / first-difference / second-difference / moving-average filter
// with per-channel history, saturating output and a single-entry output register.
module multichan_diff_filter #(
    parameter int DW       = 16,
    parameter int CH       = 4,
    parameter int AVG_LOG2 = 3
) (
    input logic                  CLK,
    input logic                  RST,
    multichan_diff_filter_if.slave bus
);
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int RW    = DW + 3;
    localparam int SW    = DW + AVG_LOG2;

    localparam logic [CHW:0]      CH_LIM   = (CHW+1)'(CH);
    localparam logic [AVG_LOG2:0] CNT_FULL = (AVG_LOG2+1)'(DEPTH);
    localparam logic [AVG_LOG2:0] CNT_AVG  = (AVG_LOG2+1)'(DEPTH - 1);
    localparam logic [AVG_LOG2:0] CNT_TWO  = (AVG_LOG2+1)'(2);
    localparam logic signed [RW-1:0] MAXV = {4'b0000, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {4'b1111, {(DW-1){1'b0}}};

    logic signed [DW-1:0] x1_q [CH];
    logic signed [DW-1:0] x1_d [CH];
    logic signed [DW-1:0] x2_q [CH];
    logic signed [DW-1:0] x2_d [CH];
    logic signed [DW-1:0] ring_q [CH][DEPTH];
    logic signed [DW-1:0] ring_d [CH][DEPTH];
    logic signed [SW-1:0] sum_q [CH];
    logic signed [SW-1:0] sum_d [CH];
    logic [AVG_LOG2-1:0]  wp_q [CH];
    logic [AVG_LOG2-1:0]  wp_d [CH];
    logic [AVG_LOG2:0]    cnt_q [CH];
    logic [AVG_LOG2:0]    cnt_d [CH];
    logic [1:0]           mode_q, mode_d;
    logic                 out_valid_q, out_valid_d;
    logic [CHW-1:0]       out_ch_q, out_ch_d;
    logic [DW-1:0]        out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;

    logic                 in_ready, accept, ch_ok, clr, emit, sat_res;
    logic [CHW-1:0]       ch_idx;
    logic signed [DW-1:0] x_in, x1_c, x2_c, old_c;
    logic signed [SW-1:0] sum_c, sum_new, avg_full;
    logic [AVG_LOG2-1:0]  wp_c;
    logic [AVG_LOG2:0]    cnt_c;
    logic signed [RW-1:0] xe, x1e, x2e, avg_e, res;
    logic [DW-1:0]        clamp_res;

    assign in_ready = !out_valid_q || bus.OUT_READY;
    assign accept   = bus.IN_VALID && in_ready;
    assign ch_ok    = ({1'b0, bus.IN_CH} < CH_LIM);
    assign ch_idx   = ch_ok ? bus.IN_CH : '0;
    assign clr      = (bus.MODE != mode_q);
    assign x_in     = bus.IN_DATA;

    // A mode change makes every channel look freshly cleared to the current beat.
    always_comb begin
        x1_c  = clr ? '0 : x1_q[ch_idx];
        x2_c  = clr ? '0 : x2_q[ch_idx];
        wp_c  = clr ? '0 : wp_q[ch_idx];
        sum_c = clr ? '0 : sum_q[ch_idx];
        cnt_c = clr ? '0 : cnt_q[ch_idx];
        old_c = clr ? '0 : ring_q[ch_idx][wp_c];
    end

    always_comb begin
        xe       = {{3{x_in[DW-1]}}, x_in};
        x1e      = {{3{x1_c[DW-1]}}, x1_c};
        x2e      = {{3{x2_c[DW-1]}}, x2_c};
        sum_new  = sum_c - {{AVG_LOG2{old_c[DW-1]}}, old_c} + {{AVG_LOG2{x_in[DW-1]}}, x_in};
        avg_full = sum_new >>> AVG_LOG2;
        avg_e    = RW'(avg_full);
        res      = xe;
        emit     = 1'b1;
        case (bus.MODE)
            2'd0: begin
                res  = xe;
                emit = 1'b1;
            end
            2'd1: begin
                res  = xe - x1e;
                emit = (cnt_c != '0);
            end
            2'd2: begin
                res  = xe - (x1e <<< 1) + x2e;
                emit = (cnt_c >= CNT_TWO);
            end
            default: begin
                res  = avg_e;
                emit = (cnt_c >= CNT_AVG);
            end
        endcase
    end

    always_comb begin
        sat_res   = 1'b0;
        clamp_res = res[DW-1:0];
        if (res > MAXV) begin
            clamp_res = MAXV[DW-1:0];
            sat_res   = 1'b1;
        end else if (res < MINV) begin
            clamp_res = MINV[DW-1:0];
            sat_res   = 1'b1;
        end
    end

    // Out-of-range channel tags are consumed without touching any state.
    always_comb begin
        x1_d        = x1_q;
        x2_d        = x2_q;
        ring_d      = ring_q;
        sum_d       = sum_q;
        wp_d        = wp_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (accept && ch_ok) begin
            mode_d = bus.MODE;
            if (clr) begin
                for (int c = 0; c < CH; c++) begin
                    x1_d[c]  = '0;
                    x2_d[c]  = '0;
                    sum_d[c] = '0;
                    wp_d[c]  = '0;
                    cnt_d[c] = '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        ring_d[c][k] = '0;
                    end
                end
            end
            x2_d[ch_idx]         = x1_c;
            x1_d[ch_idx]         = x_in;
            ring_d[ch_idx][wp_c] = x_in;
            wp_d[ch_idx]         = wp_c + 1'b1;
            sum_d[ch_idx]        = sum_new;
            cnt_d[ch_idx]        = (cnt_c == CNT_FULL) ? cnt_c : cnt_c + 1'b1;
        end
        if (accept) begin
            out_valid_d = ch_ok && emit;
            if (ch_ok && emit) begin
                out_ch_d   = bus.IN_CH;
                out_data_d = clamp_res;
                out_sat_d  = sat_res;
            end
        end else if (bus.OUT_READY) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < CH; c++) begin
                x1_q[c]  <= '0;
                x2_q[c]  <= '0;
                sum_q[c] <= '0;
                wp_q[c]  <= '0;
                cnt_q[c] <= '0;
                for (int k = 0; k < DEPTH; k++) begin
                    ring_q[c][k] <= '0;
                end
            end
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            x1_q        <= x1_d;
            x2_q        <= x2_d;
            ring_q      <= ring_d;
            sum_q       <= sum_d;
            wp_q        <= wp_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_CH    = out_ch_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_SAT   = out_sat_q;
endmodule

// File: tb/tb_multichan_diff_filter.sv
// Scoreboard bench for multichan_diff_filter: directed beats push expected results,
// a monitor pops and compares every result the DUT hands downstream.
module tb_multichan_diff_filter;
    localparam int DW       = 16;
    localparam int CH       = 3;
    localparam int AVG_LOG2 = 2;
    localparam int CHW      = 2;

    typedef struct {
        logic [CHW-1:0]       ch;
        logic signed [DW-1:0] data;
        logic                 sat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    time  t0;

    always #5 CLK = ~CLK;

    multichan_diff_filter_if #(.DW(DW), .CHW(CHW)) bus();

    multichan_diff_filter #(.DW(DW), .CH(CH), .AVG_LOG2(AVG_LOG2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one beat, wait (bounded) for acceptance, and record what should come out.
    task automatic applyStimulus(input int ch, input int data, input int mode,
                                 input bit expv, input int expd, input bit exps);
        exp_t e;
        int   waited = 0;
        bus.IN_CH    = ch[CHW-1:0];
        bus.IN_DATA  = data[DW-1:0];
        bus.MODE     = mode[1:0];
        bus.IN_VALID = 1'b1;
        @(negedge CLK);
        while (!bus.IN_READY && waited < 50) begin
            waited++;
            @(negedge CLK);
        end
        if (!bus.IN_READY) checkOutput("accept_timeout", 0, 1);
        if (expv) begin
            e.ch   = ch[CHW-1:0];
            e.data = expd[DW-1:0];
            e.sat  = exps;
            sb_q.push_back(e);
        end
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        if (!expv) checkOutput("no_output", int'(bus.OUT_VALID), 0);
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && bus.OUT_VALID && bus.OUT_READY) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput("out_ch", int'(bus.OUT_CH), int'(mon_e.ch));
                    checkOutput("out_data", int'($signed(bus.OUT_DATA)), int'(mon_e.data));
                    checkOutput("out_sat", int'(bus.OUT_SAT), int'(mon_e.sat));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        RST           = 1'b1;
        bus.IN_VALID  = 1'b0;
        bus.IN_CH     = '0;
        bus.IN_DATA   = '0;
        bus.MODE      = 2'd0;
        bus.OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_out_valid", int'(bus.OUT_VALID), 0);
        checkOutput("rst_out_data", int'(bus.OUT_DATA), 0);
        checkOutput("rst_out_ch", int'(bus.OUT_CH), 0);
        checkOutput("rst_out_sat", int'(bus.OUT_SAT), 0);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("rst_in_ready", int'(bus.IN_READY), 1);
        @(posedge CLK);
        #1;

        // Second difference on ch0.
        applyStimulus(0, 10, 2, 0, 0, 0);
        applyStimulus(0, 20, 2, 0, 0, 0);
        applyStimulus(0, 40, 2, 1, 10, 0);
        applyStimulus(0, 70, 2, 1, 10, 0);

        // First difference, interleaved channels; mode change 2->1 suppresses the next beat.
        applyStimulus(0, 5,   1, 0, 0, 0);
        applyStimulus(1, 100, 1, 0, 0, 0);
        applyStimulus(0, 8,   1, 1, 3, 0);
        applyStimulus(1, 90,  1, 1, -10, 0);
        applyStimulus(0, 3,   1, 1, -5, 0);

        // Four-point moving average on ch2, then a floor check on ch1.
        applyStimulus(2, 4,   3, 0, 0, 0);
        applyStimulus(2, 8,   3, 0, 0, 0);
        applyStimulus(2, 12,  3, 0, 0, 0);
        applyStimulus(2, 16,  3, 1, 10, 0);
        applyStimulus(2, 20,  3, 1, 14, 0);
        applyStimulus(2, -40, 3, 1, 2, 0);
        applyStimulus(1, -1,  3, 0, 0, 0);
        applyStimulus(1, 0,   3, 0, 0, 0);
        applyStimulus(1, 0,   3, 0, 0, 0);
        applyStimulus(1, 0,   3, 1, -1, 0);

        // Saturation at both rails in second-difference mode.
        applyStimulus(0, 32767,  2, 0, 0, 0);
        applyStimulus(0, -32768, 2, 0, 0, 0);
        applyStimulus(0, 32767,  2, 1, 32767, 1);
        applyStimulus(0, -32768, 2, 1, -32768, 1);

        // Out-of-range channel tag must leave ch0 history untouched.
        applyStimulus(0, 5,  1, 0, 0, 0);
        applyStimulus(3, 50, 1, 0, 0, 0);
        applyStimulus(0, 7,  1, 1, 2, 0);

        // Backpressure: hold a result while a new beat waits.
        applyStimulus(1, 10, 1, 0, 0, 0);
        applyStimulus(1, 20, 1, 1, 10, 0);
        bus.OUT_READY = 1'b0;
        bus.IN_CH     = 2'd1;
        bus.IN_DATA   = 16'd35;
        bus.MODE      = 2'd1;
        bus.IN_VALID  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checkOutput("bp_in_ready", int'(bus.IN_READY), 0);
            checkOutput("bp_out_valid", int'(bus.OUT_VALID), 1);
            checkOutput("bp_out_data", int'($signed(bus.OUT_DATA)), 10);
            checkOutput("bp_out_ch", int'(bus.OUT_CH), 1);
        end
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b1;
        t0 = $time;
        applyStimulus(1, 35, 1, 1, 15, 0);
        applyStimulus(1, 40, 1, 1, 5, 0);
        applyStimulus(1, 60, 1, 1, 20, 0);
        checkOutput("throughput_cycles", int'(($time - t0) / 10), 3);

        // Reset mid-stream discards a held result and warm-up progress.
        applyStimulus(0, 1, 2, 0, 0, 0);
        applyStimulus(0, 2, 2, 0, 0, 0);
        bus.OUT_READY = 1'b0;
        bus.IN_CH     = 2'd0;
        bus.IN_DATA   = 16'd4;
        bus.MODE      = 2'd2;
        bus.IN_VALID  = 1'b1;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        checkOutput("held_before_reset", int'(bus.OUT_VALID), 1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        checkOutput("mid_rst_out_valid", int'(bus.OUT_VALID), 0);
        checkOutput("mid_rst_out_data", int'(bus.OUT_DATA), 0);
        checkOutput("mid_rst_out_ch", int'(bus.OUT_CH), 0);
        checkOutput("mid_rst_out_sat", int'(bus.OUT_SAT), 0);
        checkOutput("mid_rst_in_ready", int'(bus.IN_READY), 1);
        bus.OUT_READY = 1'b1;
        applyStimulus(0, 3, 2, 0, 0, 0);
        applyStimulus(0, 5, 2, 0, 0, 0);
        applyStimulus(0, 9, 2, 1, 2, 0);

        repeat (5) @(posedge CLK);
        #1;
        checkOutput("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
